nonce_search_ctrl: RTL

//  Sequencer that sits directly upstream of the micro-hash core.
//  - Latches the 12-byte block header and the target.
//  - Sweeps nonces from nonce_base to nonce_last, issuing one hash request per nonce.
//  - Checks each 24-bit hash against the target.
//  - Stops on the first passing nonce, on range exhaustion, on abort, or on hash timeout.

---
 rtl/nonce_search_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nonce_search_ctrl.sv
// Nonce sweep sequencer in front of the micro-hash core; `SEARCH_STATS_EN adds the attempts counter.
// Latency: start to first hash_start 1 cycle, at least 3 cycles per nonce (ISSUE, WAIT, CHECK).
// Backpressure: start ignored while busy; waits up to TIMEOUT cycles for hash_done, then errors out.
module nonce_search_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [95:0] header_in,
  input  logic [7:0]  target_in,
  input  logic [31:0] nonce_base,
  input  logic [31:0] nonce_last,
  input  logic [23:0] hash_in,
  input  logic        hash_done,
  output logic        selector,
  output logic [95:0] data_entry_12,
  output logic [31:0] data_nonce,
  output logic [7:0]  data_target,
  output logic        hash_start,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        exhausted,
  output logic        err_timeout,
  output logic [31:0] nonce_found,
`ifdef SEARCH_STATS_EN
  output logic [31:0] attempts,
`endif
  output logic [23:0] hash_found
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] nonce_last_q;
  logic [23:0] hash_q;
  logic [7:0]  wait_cnt;
  logic        pass, last_nonce, wait_expired;

  assign pass         = (hash_q[23:16] < data_target) && (hash_q[15:8] < data_target);
  assign last_nonce   = (data_nonce == nonce_last_q);
  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign busy         = (state_q != S_IDLE);
  assign selector     = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);

  // abort overrides every transition and suppresses the request and done pulses
  always_comb begin
    state_d    = state_q;
    hash_start = 1'b0;
    done       = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_ISSUE;
        S_ISSUE: begin
          hash_start = 1'b1;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (hash_done)         state_d = S_CHECK;
          else if (wait_expired) state_d = S_DONE;
        end
        S_CHECK: state_d = (pass || last_nonce) ? S_DONE : S_ISSUE;
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_entry_12 <= '0;
      data_nonce    <= '0;
      data_target   <= '0;
      nonce_last_q  <= '0;
      hash_q        <= '0;
      wait_cnt      <= '0;
      found         <= 1'b0;
      exhausted     <= 1'b0;
      err_timeout   <= 1'b0;
      nonce_found   <= '0;
      hash_found    <= '0;
`ifdef SEARCH_STATS_EN
      attempts      <= '0;
`endif
    end else if (!abort) begin
      case (state_q)
        S_IDLE: if (start) begin
          data_entry_12 <= header_in;
          data_target   <= target_in;
          data_nonce    <= nonce_base;
          nonce_last_q  <= nonce_last;
          found         <= 1'b0;
          exhausted     <= 1'b0;
          err_timeout   <= 1'b0;
          nonce_found   <= '0;
          hash_found    <= '0;
`ifdef SEARCH_STATS_EN
          attempts      <= '0;
`endif
        end
        S_ISSUE: begin
          wait_cnt <= '0;
`ifdef SEARCH_STATS_EN
          if (attempts != 32'hFFFF_FFFF) attempts <= attempts + 32'd1;
`endif
        end
        S_WAIT: begin
          if (hash_done)         hash_q      <= hash_in;
          else if (wait_expired) err_timeout <= 1'b1;
          else                   wait_cnt    <= wait_cnt + 8'd1;
        end
        S_CHECK: begin
          if (pass) begin
            found       <= 1'b1;
            nonce_found <= data_nonce;
            hash_found  <= hash_q;
          end else if (last_nonce) begin
            exhausted <= 1'b1;
          end else begin
            data_nonce <= data_nonce + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
